// File: rtl/reg_dump_unit.sv
// reg_dump_unit: walks a register-file address range and shifts each word out serially, MSB first
module reg_dump_unit #(
  parameter int FIRST_REG  = 0,
  parameter int LAST_REG   = 15,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic [3:0]            o_dump_addr,
  input  logic [DATA_WIDTH-1:0] i_dump_data,
  output logic                  o_out_bit,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_out_last,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);
  localparam logic [3:0] FIRST_A = 4'(FIRST_REG);
  localparam logic [3:0] LAST_A  = 4'(LAST_REG);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_addr;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic                  w_xfer;
  logic                  w_word_end;
  logic                  w_last_reg;

  // abort beats any same-cycle transfer, so it gates the handshake here
  assign w_xfer     = (r_state == S_SHIFT) && i_out_ready && !i_abort;
  assign w_word_end = w_xfer && (r_cnt == LAST_CNT);
  assign w_last_reg = (r_addr == LAST_A);

  // state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // next-state: abort returns to IDLE from anywhere, otherwise walk FETCH/SHIFT per word
  always_comb begin
    w_next = r_state;
    w_next = i_abort               ? S_IDLE :
             (r_state == S_IDLE)  ? (i_start ? S_FETCH : S_IDLE) :
             (r_state == S_FETCH) ? S_SHIFT :
             (r_state == S_SHIFT) ? (w_word_end ? (w_last_reg ? S_DONE : S_FETCH) : S_SHIFT) :
                                    S_IDLE;
  end

  // address walk, word capture and MSB-first shifting
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_addr  <= FIRST_A;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_next == S_IDLE)             r_addr <= FIRST_A;
      else if (w_word_end && !w_last_reg) r_addr <= r_addr + 4'd1;
      if (r_state == S_FETCH && !i_abort) begin
        r_shift <= i_dump_data;
        r_cnt   <= '0;
      end else if (w_xfer) begin
        r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

  assign o_dump_addr = r_addr;
  assign o_out_valid = (r_state == S_SHIFT);
  assign o_out_bit   = o_out_valid && r_shift[DATA_WIDTH-1];
  assign o_out_last  = o_out_valid && w_last_reg && (r_cnt == LAST_CNT);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit: directed bench with a bit-queue model of the expected serial stream
module tb_reg_dump_unit;
  logic        clk = 1'b0;
  logic        i_reset, i_start, i_abort, i_out_ready;
  logic [3:0]  o_dump_addr;
  logic [15:0] dump_data;
  logic        o_out_bit, o_out_valid, o_out_last, o_busy, o_done;
  logic        start2, abort2, ready2;
  logic [3:0]  addr2;
  logic [15:0] data2;
  logic        bit2, valid2, last2, busy2, done2;
  logic [15:0] regs [16];

  int checks = 0, fails = 0, cyc = 0, k = 0;
  int done_cnt = 0, done_cyc = 0;
  int done2_cnt = 0, done2_cyc = 0, last2_idx = 0, last2_cnt = 0;
  bit exp_q [$];
  bit got_q [$];
  bit got2 [$];
  bit full = 1'b0;

  always #5 clk = ~clk;

  assign dump_data = regs[o_dump_addr];
  assign data2     = regs[addr2];

  reg_dump_unit dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .o_dump_addr(o_dump_addr), .i_dump_data(dump_data), .o_out_bit(o_out_bit),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_last(o_out_last),
    .o_busy(o_busy), .o_done(o_done)
  );

  reg_dump_unit #(.FIRST_REG(12), .LAST_REG(12), .DATA_WIDTH(16)) dut2 (
    .i_clk(clk), .i_reset(i_reset), .i_start(start2), .i_abort(abort2),
    .o_dump_addr(addr2), .i_dump_data(data2), .o_out_bit(bit2),
    .o_out_valid(valid2), .i_out_ready(ready2), .o_out_last(last2),
    .o_busy(busy2), .o_done(done2)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  function automatic logic [15:0] word_at(input int base);
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++) w = {w[14:0], (base + i < got_q.size()) ? got_q[base + i] : 1'b0};
    return w;
  endfunction

  // compares the DUT against the expected-bit queue once per cycle, away from the edge
  task automatic monitor();
    if (i_reset) return;
    if (!o_busy) begin
      chk("idle_valid", {31'd0, o_out_valid}, 0);
      chk("idle_done", {31'd0, o_done}, 0);
    end
    if (o_out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL extra_bit got=valid exp=no_bit (cycle %0d)", cyc);
      end else begin
        chk("bit", {31'd0, o_out_bit}, {31'd0, exp_q[0]});
        chk("last", {31'd0, o_out_last}, {31'd0, full && exp_q.size() == 1});
        if (i_out_ready && !i_abort) begin
          got_q.push_back(o_out_bit);
          void'(exp_q.pop_front());
        end
      end
    end else chk("last_novalid", {31'd0, o_out_last}, 0);
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc + 1;
    end
    if (valid2 && ready2) begin
      got2.push_back(bit2);
      if (last2) begin
        last2_idx = got2.size();
        last2_cnt++;
      end
    end
    if (done2) begin
      done2_cnt++;
      done2_cyc = cyc + 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic begin_dump();
    exp_q.delete();
    got_q.delete();
    for (int r = 0; r < 16; r++)
      for (int b = 15; b >= 0; b--) exp_q.push_back(regs[r][b]);
    full = 1'b1;
    done_cnt = 0;
    i_out_ready = 1'b1;
    i_start = 1'b1;
    k = cyc + 1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      if (toggle) i_out_ready = ~i_out_ready;
      tick();
      n++;
    end
    chk("done_seen", done_cnt, 1);
  endtask

  initial begin
    int n;
    i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_out_ready = 1'b0;
    start2 = 1'b0; abort2 = 1'b0; ready2 = 1'b1;
    for (int i = 0; i < 16; i++) regs[i] = 16'(i * 16'h1111);
    regs[0] = 16'hA5C3;
    tick(); tick();
    chk("rst_addr", {28'd0, o_dump_addr}, 0);
    chk("rst_valid", {31'd0, o_out_valid}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_done", {31'd0, o_done}, 0);
    chk("rst_addr2", {28'd0, addr2}, 12);
    i_reset = 1'b0;
    tick();

    // full dump with the sink always ready
    begin_dump();
    wait_done(400, 1'b0);
    chk("t1_latency", done_cyc - k, 273);
    chk("t1_bits", got_q.size(), 256);
    chk("t1_word0", {16'd0, word_at(0)}, 32'hA5C3);
    chk("t1_word15", {16'd0, word_at(240)}, 32'hFFFF);
    chk("t1_left", exp_q.size(), 0);
    tick();
    chk("t1_busy_after", {31'd0, o_busy}, 0);
    chk("t1_addr_after", {28'd0, o_dump_addr}, 0);

    // same dump with ready alternating every cycle
    begin_dump();
    wait_done(800, 1'b1);
    chk("t2_bits", got_q.size(), 256);
    chk("t2_word0", {16'd0, word_at(0)}, 32'hA5C3);
    chk("t2_slow", {31'd0, (done_cyc - k) >= 500 && (done_cyc - k) <= 560}, 1);
    i_out_ready = 1'b1;
    tick();

    // abort while r5 bit 7 is on the line
    begin_dump();
    n = 0;
    while (got_q.size() != 88 && n < 200) begin tick(); n++; end
    chk("t3_reach", got_q.size(), 88);
    chk("t3_addr5", {28'd0, o_dump_addr}, 5);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    exp_q.delete();
    full = 1'b0;
    chk("t3_valid", {31'd0, o_out_valid}, 0);
    chk("t3_busy", {31'd0, o_busy}, 0);
    chk("t3_addr", {28'd0, o_dump_addr}, 0);
    repeat (5) tick();
    chk("t3_no_done", done_cnt, 0);
    begin_dump();
    wait_done(400, 1'b0);
    chk("t3_restart_bit", {31'd0, got_q[0]}, 1);
    chk("t3_restart_word", {16'd0, word_at(0)}, 32'hA5C3);
    chk("t3_restart_bits", got_q.size(), 256);

    // asynchronous reset between edges mid-shift
    begin_dump();
    repeat (50) tick();
    #2 i_reset = 1'b1;
    #1;
    chk("t4_valid", {31'd0, o_out_valid}, 0);
    chk("t4_bit", {31'd0, o_out_bit}, 0);
    chk("t4_last", {31'd0, o_out_last}, 0);
    chk("t4_busy", {31'd0, o_busy}, 0);
    chk("t4_done", {31'd0, o_done}, 0);
    chk("t4_addr", {28'd0, o_dump_addr}, 0);
    tick(); tick();
    i_reset = 1'b0;
    exp_q.delete();
    full = 1'b0;
    tick();
    begin_dump();
    wait_done(400, 1'b0);
    chk("t4_latency", done_cyc - k, 273);
    chk("t4_bits", got_q.size(), 256);

    // start while busy at r3 is ignored
    begin_dump();
    n = 0;
    while (got_q.size() != 53 && n < 200) begin tick(); n++; end
    chk("t5_addr3", {28'd0, o_dump_addr}, 3);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(400, 1'b0);
    chk("t5_latency", done_cyc - k, 273);
    chk("t5_bits", got_q.size(), 256);
    repeat (3) tick();
    chk("t5_one_done", done_cnt, 1);
    chk("t5_idle", {31'd0, o_busy}, 0);

    // single-register range
    regs[12] = 16'h8001;
    got2.delete();
    done2_cnt = 0;
    start2 = 1'b1;
    k = cyc + 1;
    tick();
    start2 = 1'b0;
    n = 0;
    while (done2_cnt == 0 && n < 40) begin tick(); n++; end
    chk("t6_done", done2_cnt, 1);
    chk("t6_latency", done2_cyc - k, 18);
    chk("t6_bits", got2.size(), 16);
    begin
      logic [15:0] w = '0;
      for (int i = 0; i < 16; i++) w = {w[14:0], (i < got2.size()) ? got2[i] : 1'b0};
      chk("t6_word", {16'd0, w}, 32'h8001);
    end
    chk("t6_last_idx", last2_idx, 16);
    chk("t6_last_cnt", last2_cnt, 1);
    tick();
    chk("t6_idle", {31'd0, busy2}, 0);
    chk("t6_addr", {28'd0, addr2}, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/reg_dump_unit.md
Name: reg_dump_unit

Overview:
- Debug read-out engine that reads the CPU register file through one of its combinational read ports.
- On a start request it walks a contiguous register-address range and captures each 16-bit word.
- Each word is shifted out serially, MSB first, under a valid/ready handshake.
- Sits beside the register file; drives a read-port address and consumes that port's data, so the CPU can be inspected without halting writeback.

Parameters:
- FIRST_REG, 0, first register address dumped (0-15).
- LAST_REG, 15, last register address dumped (FIRST_REG..15).
- DATA_WIDTH, 16, register word width; the bit counter spans DATA_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  dump request; sampled in IDLE only.
- abort  input  1  synchronous cancel of a dump in progress.
- dump_addr  output  4  register read address, to register-file read port.
- dump_data  input  DATA_WIDTH  read data returned combinationally for dump_addr.
- out_bit  output  1  serial data bit, MSB first.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  sink accepts out_bit this cycle.
- out_last  output  1  current bit is bit 0 of LAST_REG.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on dump completion.

Behaviour:
- Reset (asynchronous, any time, including mid-dump):
  - state=IDLE, dump_addr=FIRST_REG, shift register=0, bit_cnt=0.
  - out_valid=0, out_bit=0, out_last=0, busy=0, done=0.
  - Next posedge after reset deasserts behaves as IDLE.
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - busy=0; dump_addr holds FIRST_REG.
  - start=1 at posedge -> FETCH.
- FETCH (exactly 1 cycle):
  - dump_addr stable; at the posedge, shift register <= dump_data and bit_cnt <= 0.
  - -> SHIFT.
  - Register-file writes on the opposite clock edge are permitted; the captured value is the one present at this posedge.
- SHIFT:
  - out_valid=1; out_bit = shift[DATA_WIDTH-1].
  - Transfer occurs when out_valid && out_ready at posedge: shift left by 1 (zero fill), bit_cnt++.
  - out_ready=0 holds out_bit, shift register and bit_cnt unchanged indefinitely.
  - Transfer with bit_cnt==DATA_WIDTH-1:
    - if dump_addr==LAST_REG -> DONE;
    - else dump_addr++ -> FETCH.
  - out_valid=0 during FETCH, so there is a one-cycle bubble between words.
- DONE (1 cycle):
  - done=1, busy=1, out_valid=0.
  - -> IDLE with dump_addr <= FIRST_REG.
- out_last = (state==SHIFT) && dump_addr==LAST_REG && bit_cnt==DATA_WIDTH-1.
- Control rules:
  - start while busy is ignored (no restart, no queueing).
  - abort=1 in FETCH/SHIFT/DONE -> IDLE next posedge: dump_addr=FIRST_REG, out_valid=0, no done pulse.
  - abort has priority over a same-cycle transfer (the transfer does not complete).
  - start and abort both high in IDLE: abort wins, stay IDLE.
- Latency:
  - start sampled at edge k -> FETCH during cycle k+1 -> first out_valid in cycle k+2.
  - With out_ready held high: (LAST_REG-FIRST_REG+1) x (DATA_WIDTH+1) cycles from first FETCH to DONE.
  - Defaults: 16 x 17 = 272 cycles; done at cycle k+273.
- Range boundary:
  - dump_addr never exceeds LAST_REG; no wrap past 15.
  - FIRST_REG==LAST_REG dumps a single word.

Test Plan:
1. Preload r0=0xA5C3, r1..r15 = index x 0x1111; pulse start with out_ready=1 -> 256 bits observed, first 16 = 1010010111000011, out_last only on final bit, done pulse at 273 cycles after start edge, busy low afterwards.
2. Same dump, out_ready toggled 1/0 every cycle -> identical bit sequence, out_bit stable while out_ready=0, total time ~2x.
3. Assert abort during r5 bit 7 -> out_valid=0 and busy=0 next cycle, no done; a new start restarts at r0 with bit 15 of r0.
4. Assert reset asynchronously mid-SHIFT (between edges) -> all outputs zero immediately, dump_addr=FIRST_REG; a start after release produces a full correct dump.
5. Pulse start again while busy at r3 -> ignored; sequence continues unchanged and one done pulse results.
6. FIRST_REG=12, LAST_REG=12, r12=0x8001 -> exactly 16 bits 1000000000000001, out_last on 16th bit, done 18 cycles after start edge.
